// File: rtl/updown_pkg.sv
// Shared definitions for the parametrised up/down push-button counter.
// Holds the counting modes and the next-count helper used by the datapath.
package updown_pkg;

  localparam logic MODE_SAT  = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

  typedef struct packed {
    logic        limit;
    logic [63:0] next;
  } cnt_result_t;

  // One step up or down; limit marks a clamp (saturate) or a wrap-around.
  function automatic cnt_result_t count_next(
    input logic [63:0] value,
    input logic [63:0] step,
    input logic [63:0] max_val,
    input logic        mode,
    input logic        up
  );
    cnt_result_t res;
    logic [63:0] sum;
    res.limit = 1'b0;
    res.next  = value;
    sum       = value + step;
    if (up) begin
      if (sum > max_val) begin
        res.limit = 1'b1;
        res.next  = (mode == MODE_WRAP) ? (sum - (max_val + 64'd1)) : max_val;
      end else begin
        res.next = sum;
      end
    end else begin
      if (value < step) begin
        res.limit = 1'b1;
        res.next  = (mode == MODE_WRAP) ? (value + max_val + 64'd1 - step) : 64'd0;
      end else begin
        res.next = value - step;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/updown_counter_param_btn_conditioner.sv
// Synchroniser, debouncer and rising-edge detector for one raw push-button.
// Emits one registered press pulse per debounced press; no auto-repeat.
module btn_conditioner #(
  parameter int DEB_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level_out,
  output logic press_out
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic [CW-1:0] r_cnt;
  logic          r_filt;
  logic          r_filt_q;
  logic          r_press;

  // The filtered level flips on the edge where the mismatch run reaches DEB_CYCLES.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_cnt    <= '0;
      r_filt   <= 1'b0;
      r_filt_q <= 1'b0;
      r_press  <= 1'b0;
    end else begin
      r_s1     <= btn_in;
      r_s2     <= r_s1;
      r_filt_q <= r_filt;
      r_press  <= r_filt & ~r_filt_q;
      if (r_s2 != r_filt) begin
        if (r_cnt == CNT_LAST) begin
          r_filt <= ~r_filt;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign level_out = r_filt;
  assign press_out = r_press;

endmodule

// File: rtl/updown_counter_param.sv
// Push-button up/down counter with saturate or wrap limits, soft clear,
// parallel load and registered limit status flags.
module updown_counter_param
  import updown_pkg::*;
#(
  parameter int              WIDTH      = 16,
  parameter longint unsigned MAX_VAL    = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned STEP       = 1,
  parameter int              WRAP       = 0,
  parameter int              DEB_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             u,
  input  logic             d,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] c_out,
  output logic             at_zero,
  output logic             at_max,
  output logic             limit_hit
);

  localparam logic [63:0]      MAX64     = 64'(MAX_VAL);
  localparam logic [63:0]      STEP64    = 64'(STEP);
  localparam logic [WIDTH-1:0] MAX_W     = MAX64[WIDTH-1:0];
  localparam logic             WRAP_MODE = (WRAP != 0) ? MODE_WRAP : MODE_SAT;

  logic             w_up_level;
  logic             w_dn_level;
  logic             w_up_press;
  logic             w_dn_press;
  logic [63:0]      w_cur;
  logic [63:0]      w_load64;
  cnt_result_t      w_res;
  logic [WIDTH-1:0] w_next;
  logic             w_limit;
  logic             w_unused;

  logic [WIDTH-1:0] r_count;
  logic             r_at_zero;
  logic             r_at_max;
  logic             r_limit;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_up (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (u),
    .level_out (w_up_level),
    .press_out (w_up_press)
  );

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_dn (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (d),
    .level_out (w_dn_level),
    .press_out (w_dn_press)
  );

  assign w_cur    = 64'(r_count);
  assign w_load64 = 64'(load_val);

  // Presses coinciding with clr/load are dropped; simultaneous up+down cancel.
  always_comb begin
    w_next  = r_count;
    w_limit = 1'b0;
    w_res   = '0;
    if (clr) begin
      w_next = '0;
    end else if (load) begin
      w_next = (w_load64 > MAX64) ? MAX_W : load_val;
    end else if (w_up_press ^ w_dn_press) begin
      w_res   = count_next(w_cur, STEP64, MAX64, WRAP_MODE, w_up_press);
      w_next  = w_res.next[WIDTH-1:0];
      w_limit = w_res.limit;
    end
  end

  assign w_unused = &{1'b0, w_up_level, w_dn_level, w_res.next[63:WIDTH]};

  // Flags come from the next-state value so they line up with c_out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count   <= '0;
      r_at_zero <= 1'b1;
      r_at_max  <= 1'b0;
      r_limit   <= 1'b0;
    end else begin
      r_count   <= w_next;
      r_at_zero <= (w_next == '0);
      r_at_max  <= (w_next == MAX_W);
      r_limit   <= w_limit;
    end
  end

  assign c_out     = r_count;
  assign at_zero   = r_at_zero;
  assign at_max    = r_at_max;
  assign limit_hit = r_limit;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: defaults, saturate and wrap
// instances share one stimulus stream; each check targets one instance.
module tb_updown_counter_param;

  logic        clk;
  logic        reset;
  logic        u;
  logic        d;
  logic        clr;
  logic        load;
  logic [15:0] load_val;

  logic [15:0] defCount;
  logic        defZero, defMax, defLimit;
  logic [15:0] satCount;
  logic        satZero, satMax, satLimit;
  logic [15:0] wrapCount;
  logic        wrapZero, wrapMax, wrapLimit;

  int errors = 0;
  int checks = 0;

  updown_counter_param dutDef (
    .clk(clk), .reset(reset), .u(u), .d(d), .clr(clr), .load(load),
    .load_val(load_val), .c_out(defCount), .at_zero(defZero),
    .at_max(defMax), .limit_hit(defLimit)
  );

  updown_counter_param #(.WIDTH(16), .MAX_VAL(9), .STEP(3), .WRAP(0), .DEB_CYCLES(2)) dutSat (
    .clk(clk), .reset(reset), .u(u), .d(d), .clr(clr), .load(load),
    .load_val(load_val), .c_out(satCount), .at_zero(satZero),
    .at_max(satMax), .limit_hit(satLimit)
  );

  updown_counter_param #(.WIDTH(16), .MAX_VAL(9), .STEP(3), .WRAP(1), .DEB_CYCLES(2)) dutWrap (
    .clk(clk), .reset(reset), .u(u), .d(d), .clr(clr), .load(load),
    .load_val(load_val), .c_out(wrapCount), .at_zero(wrapZero),
    .at_max(wrapMax), .limit_hit(wrapLimit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Press the selected buttons for 3 cycles; returns just after the update edge.
  task automatic applyStimulus(input logic up, input logic dn);
    u = up;
    d = dn;
    tick(3);
    u = 1'b0;
    d = 1'b0;
    tick(3);
  endtask

  logic [15:0] satExp [4] = '{16'd3, 16'd6, 16'd9, 16'd9};
  logic        satLim [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    u = 1'b0; d = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0; reset = 1'b0;
    tick(2);
    reset = 1'b1;
    checkOutput("rst_count", 64'(defCount), 64'd0);
    checkOutput("rst_zero", 64'(defZero), 64'd1);
    checkOutput("rst_max", 64'(defMax), 64'd0);
    checkOutput("rst_limit", 64'(defLimit), 64'd0);

    // Latency: edge E+4 still old value, E+5 updated
    u = 1'b1;
    tick(3);
    u = 1'b0;
    tick(2);
    checkOutput("t1_before_e5", 64'(defCount), 64'd0);
    tick(1);
    checkOutput("t1_at_e5", 64'(defCount), 64'd1);
    checkOutput("t1_zero", 64'(defZero), 64'd0);
    tick(7);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t1_up2", 64'(defCount), 64'd2);
    tick(7);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t1_down", 64'(defCount), 64'd1);
    tick(7);

    u = 1'b1;
    tick(1);
    u = 1'b0;
    tick(8);
    checkOutput("t2_glitch", 64'(defCount), 64'd1);
    u = 1'b1;
    tick(50);
    u = 1'b0;
    tick(8);
    checkOutput("t2_held", 64'(defCount), 64'd2);

    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    checkOutput("t3_rst", 64'(satCount), 64'd0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t3_dn_count", 64'(satCount), 64'd0);
    checkOutput("t3_dn_limit", 64'(satLimit), 64'd1);
    tick(1);
    checkOutput("t3_dn_limit_end", 64'(satLimit), 64'd0);
    tick(6);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("t3_up%0d_count", i), 64'(satCount), 64'(satExp[i]));
      checkOutput($sformatf("t3_up%0d_limit", i), 64'(satLimit), 64'(satLim[i]));
      tick(7);
    end
    checkOutput("t3_at_max", 64'(satMax), 64'd1);

    load_val = 16'd8;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    checkOutput("t4_load", 64'(wrapCount), 64'd8);
    checkOutput("t4_load_limit", 64'(wrapLimit), 64'd0);
    checkOutput("t4_load_max", 64'(wrapMax), 64'd0);
    tick(6);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t4_up_wrap", 64'(wrapCount), 64'd1);
    checkOutput("t4_up_limit", 64'(wrapLimit), 64'd1);
    tick(1);
    checkOutput("t4_up_limit_end", 64'(wrapLimit), 64'd0);
    tick(6);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t4_dn_wrap", 64'(wrapCount), 64'd8);
    checkOutput("t4_dn_limit", 64'(wrapLimit), 64'd1);
    checkOutput("t4_sat_track", 64'(satCount), 64'd6);
    tick(7);

    applyStimulus(1'b1, 1'b1);
    checkOutput("t5_both_wrap", 64'(wrapCount), 64'd8);
    checkOutput("t5_both_limit", 64'(wrapLimit), 64'd0);
    checkOutput("t5_both_sat", 64'(satCount), 64'd6);
    tick(7);
    load_val = 16'd20;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    checkOutput("t5_load_clamp", 64'(satCount), 64'd9);
    checkOutput("t5_load_max", 64'(satMax), 64'd1);
    checkOutput("t5_load_limit", 64'(satLimit), 64'd0);
    checkOutput("t5_load_def", 64'(defCount), 64'd20);
    clr = 1'b1;
    load = 1'b1;
    tick(1);
    clr = 1'b0;
    load = 1'b0;
    checkOutput("t5_clr_sat", 64'(satCount), 64'd0);
    checkOutput("t5_clr_zero", 64'(satZero), 64'd1);
    checkOutput("t5_clr_def", 64'(defCount), 64'd0);
    tick(6);

    // Reset while u is mid-debounce; u stays held through the release
    u = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(4);
    checkOutput("t6_r3", 64'(defCount), 64'd0);
    tick(1);
    checkOutput("t6_r4", 64'(defCount), 64'd0);
    tick(1);
    checkOutput("t6_r5", 64'(defCount), 64'd1);
    checkOutput("t6_zero", 64'(defZero), 64'd0);
    u = 1'b0;
    tick(8);
    checkOutput("t6_once", 64'(defCount), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised successor to the single-channel up/down push-button counter (`top_system`).
- Two raw buttons, `u` and `d`, each pass through a synchroniser, a debouncer and an edge detector.
- The resulting press events drive a WIDTH-bit counter that either saturates or wraps at 0 and at MAX_VAL, with a programmable step.
- Adds a soft clear, a parallel load and limit status flags; sits directly behind the board push-buttons and feeds the display path.

Parameters:
- WIDTH, 16, counter width in bits.
- MAX_VAL, 2**WIDTH-1, upper count limit; must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
- STEP, 1, increment/decrement per press; must satisfy 1 <= STEP <= MAX_VAL.
- WRAP, 0, 0 = saturate at the limits, 1 = wrap modulo MAX_VAL+1.
- DEB_CYCLES, 2, consecutive stable synchronised samples needed before the filtered level changes; must be >= 1.

Ports:
- clk  in  1  system clock; everything is on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- u  in  1  raw up button, asynchronous, active-high.
- d  in  1  raw down button, asynchronous, active-high.
- clr  in  1  synchronous soft clear, active-high.
- load  in  1  synchronous parallel load strobe, active-high.
- load_val  in  WIDTH  value loaded when load=1.
- c_out  out  WIDTH  current count, registered.
- at_zero  out  1  registered; 1 when c_out == 0.
- at_max  out  1  registered; 1 when c_out == MAX_VAL.
- limit_hit  out  1  registered, one-cycle pulse; 1 when the last applied event was clamped (saturate) or wrapped (wrap).

Behaviour:
- Reset: sampled only on a clk edge with reset=0.
  - Values: c_out=0, at_zero=1, at_max=0, limit_hit=0.
  - All synchroniser, debounce and edge-detect state is cleared; filtered levels go to 0.
  - Reset mid-debounce discards partial counts.
  - A button still held when reset releases counts as one press, once debounce completes.
- Conditioning (per button, identical for u and d):
  - 2-FF synchroniser s1 -> s2.
  - Stability counter increments while s2 != filt and zeroes when they match.
  - filt toggles on the edge where the counter reaches DEB_CYCLES.
  - press = filt & ~filt_q, registered as a one-cycle pulse.
  - A glitch shorter than DEB_CYCLES samples produces no press.
  - A held button produces exactly one press; there is no auto-repeat.
  - Release is debounced the same way.
- Latency: if u first samples 1 at edge E and stays high, c_out changes at edge E+DEB_CYCLES+3 (edge E+5 with defaults).
- Update priority per cycle: reset > clr > load > press events.
  - clr=1: c_out <= 0.
  - load=1: c_out <= min(load_val, MAX_VAL).
  - clr and load do not assert limit_hit.
  - up_press and dn_press in the same cycle: no change, limit_hit=0.
  - up_press only: sum = c_out + STEP, computed in WIDTH+1 bits.
    - Saturate: if sum > MAX_VAL then c_out <= MAX_VAL, limit_hit=1; else c_out <= sum.
    - Wrap: if sum > MAX_VAL then c_out <= sum - (MAX_VAL+1), limit_hit=1; else c_out <= sum.
  - dn_press only:
    - Saturate: if c_out < STEP then c_out <= 0, limit_hit=1; else c_out <= c_out - STEP.
    - Wrap: if c_out < STEP then c_out <= c_out + MAX_VAL + 1 - STEP, limit_hit=1; else c_out <= c_out - STEP.
  - An event while already at the saturating limit holds the value and still pulses limit_hit.
- Flags:
  - at_zero and at_max are registered from the next-state value, so they are coherent with c_out in the same cycle.
  - limit_hit is high for exactly the cycle after the edge on which the clamped or wrapped update took effect, then returns to 0.
- Press events that coincide with clr or load are discarded, not queued.

Decomposition:
- Package `updown_pkg`:
  - localparams MODE_SAT=0 and MODE_WRAP=1.
  - A helper function computing the next count (value, step, max, mode) -> {limit, next}, shared with the bench's reference model.
- Sub-module `btn_conditioner`:
  - Parameter DEB_CYCLES.
  - Ports: clk, reset, btn_in, level_out, press_out.
  - Instantiated twice, once for u and once for d.

Test Plan:
1. Defaults; reset low 2 cycles, then high; u high 3 cycles, then low -> c_out=1 at edge E+5, at_zero=0. Repeat u -> c_out=2. One d press -> c_out=1.
2. Glitch filter: u high 1 cycle (DEB_CYCLES=2) -> c_out unchanged. u held 50 cycles -> c_out increments exactly once.
3. Saturate, MAX_VAL=9, STEP=3: reset, then d press -> c_out=0 and limit_hit pulses one cycle. Four u presses -> 3, 6, 9, 9; limit_hit on the 4th only; at_max=1.
4. Wrap (WRAP=1), MAX_VAL=9, STEP=3: load_val=8, then u press -> c_out=1, limit_hit=1. d press -> c_out=8, limit_hit=1.
5. u and d pressed together -> c_out unchanged, limit_hit=0. load_val=20 with MAX_VAL=9 -> c_out=9. clr and load both asserted -> c_out=0.
6. Reset mid-debounce: u rises, reset pulsed low 1 cycle while u stays held -> after reset, exactly one increment at DEB_CYCLES+3 edges past release; c_out=1.
